bit_serial_adder: RTL

Sequential bit-serial ripple adder, the additive counterpart to the team's full-subtractor cells. It latches two WIDTH-bit operands and a carry-in on a start request. It then runs one full-adder stage per clock, LSB first, through a single carry flip-flop, and presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the serial arithmetic building block for area-constrained datapaths and is exercised by the team's self-checking benches alongside the combinational adder and subtractor cells.

---
 rtl/bit_serial_adder_if.sv | 24 ++
 rtl/bit_serial_adder.sv | 96 +++++++++
 2 files changed

// File: rtl/bit_serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The requester drives the master side; the adder is the slave.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder stage per clock,
// LSB first, single carry flop, registered result and done pulse.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_nxt;
  logic [WIDTH:0]   rs_cat;
  logic [WIDTH-1:0] rs_nxt;
  logic             last;
  logic             unused_rs_lsb;

  // One full-adder stage and the next partial sum.
  // The partial-sum LSB falls off the end and is never read.
  always_comb begin
    s             = ra[0] ^ rb[0] ^ c;
    c_nxt         = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
    rs_cat        = {s, rs};
    rs_nxt        = rs_cat[WIDTH:1];
    unused_rs_lsb = rs_cat[0];
    last          = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ra       <= '0;
      rb       <= '0;
      rs       <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Sum  <= '0;
      bus.Cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            ra       <= bus.A;
            rb       <= bus.B;
            c        <= bus.Cin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        SHIFT: begin
          rs  <= rs_nxt;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          c   <= c_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.Sum  <= rs_nxt;
            bus.Cout <= c_nxt;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
